// File: rtl/stopwatch_ctrl.sv
// Stopwatch control and counting core.
// Sequences IDLE/RUN/LAP/PAUSE from debounced button pulses, prescales the
// divider tick into one-second steps and keeps an MM:SS BCD count.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   tick       one-cycle divider enable, counted only in RUN or LAP
//   btn_ss     start/stop pulse
//   btn_lc     lap/clear pulse
//   disp_bcd   registered {min_tens, min_ones, sec_tens, sec_ones}
//   running    high in RUN and LAP
//   lap_active high in LAP, while the display is frozen
//   wrap       one-cycle pulse after the count rolls over to 00:00
module stopwatch_ctrl #(
  parameter int unsigned TICKS_PER_COUNT = 100,
  parameter int unsigned MAX_MIN_TENS    = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_lc,
  output logic [15:0] disp_bcd,
  output logic        running,
  output logic        lap_active,
  output logic        wrap
);

  localparam int unsigned PRESC_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_LAP   = 2'd2,
    ST_PAUSE = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [PRESC_W-1:0]   r_presc;
  logic [3:0]           r_sec_ones;
  logic [3:0]           r_sec_tens;
  logic [3:0]           r_min_ones;
  logic [3:0]           r_min_tens;
  logic [15:0]          r_disp;
  logic                 r_running;
  logic                 r_lap_active;
  logic                 r_wrap;
  logic                 w_cnt_en;
  logic                 w_presc_done;
  logic                 w_at_max;
  logic                 w_clear;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state and datapath strobes; btn_ss has priority over btn_lc.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_cnt_en     = tick && ((r_state == ST_RUN) || (r_state == ST_LAP));
    w_presc_done = (r_presc == PRESC_W'(TICKS_PER_COUNT - 1));
    w_at_max     = (r_min_tens == 4'(MAX_MIN_TENS)) && (r_min_ones == 4'd9) &&
                   (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
    case (r_state)
      ST_IDLE: begin
        if (btn_ss) w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (btn_ss)      w_next_state = ST_PAUSE;
        else if (btn_lc) w_next_state = ST_LAP;
      end
      ST_LAP: begin
        if (btn_ss)      w_next_state = ST_PAUSE;
        else if (btn_lc) w_next_state = ST_RUN;
      end
      ST_PAUSE: begin
        if (btn_ss) w_next_state = ST_RUN;
        else if (btn_lc) begin
          w_next_state = ST_IDLE;
          w_clear      = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Prescaler, cascaded BCD count, display capture and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc      <= '0;
      r_sec_ones   <= '0;
      r_sec_tens   <= '0;
      r_min_ones   <= '0;
      r_min_tens   <= '0;
      r_disp       <= '0;
      r_running    <= 1'b0;
      r_lap_active <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_running    <= (w_next_state == ST_RUN) || (w_next_state == ST_LAP);
      r_lap_active <= (w_next_state == ST_LAP);
      r_wrap       <= w_cnt_en && w_presc_done && w_at_max;

      if (w_clear) begin
        r_presc    <= '0;
        r_sec_ones <= '0;
        r_sec_tens <= '0;
        r_min_ones <= '0;
        r_min_tens <= '0;
      end else if (w_cnt_en) begin
        if (w_presc_done) begin
          r_presc <= '0;
          if (r_sec_ones == 4'd9) begin
            r_sec_ones <= '0;
            if (r_sec_tens == 4'd5) begin
              r_sec_tens <= '0;
              if (r_min_ones == 4'd9) begin
                r_min_ones <= '0;
                if (r_min_tens == 4'(MAX_MIN_TENS)) r_min_tens <= '0;
                else                                r_min_tens <= r_min_tens + 4'd1;
              end else begin
                r_min_ones <= r_min_ones + 4'd1;
              end
            end else begin
              r_sec_tens <= r_sec_tens + 4'd1;
            end
          end else begin
            r_sec_ones <= r_sec_ones + 4'd1;
          end
        end else begin
          r_presc <= r_presc + PRESC_W'(1);
        end
      end

      // Frozen while in LAP; the RUN->LAP edge itself captures the live count.
      if (r_state != ST_LAP)
        r_disp <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
    end
  end

  assign disp_bcd   = r_disp;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl.
// Instance a uses TICKS_PER_COUNT=2, instance b uses TICKS_PER_COUNT=1.
module tb_stopwatch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_a = 1'b0, ss_a = 1'b0, lc_a = 1'b0;
  logic        tick_b = 1'b0, ss_b = 1'b0, lc_b = 1'b0;
  logic [15:0] disp_a, disp_b;
  logic        run_a, lap_a, wrap_a;
  logic        run_b, lap_b, wrap_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICKS_PER_COUNT(2), .MAX_MIN_TENS(5)) u_dut_a (
    .clk(clk), .rst(rst), .tick(tick_a), .btn_ss(ss_a), .btn_lc(lc_a),
    .disp_bcd(disp_a), .running(run_a), .lap_active(lap_a), .wrap(wrap_a)
  );

  stopwatch_ctrl #(.TICKS_PER_COUNT(1), .MAX_MIN_TENS(5)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick_b), .btn_ss(ss_b), .btn_lc(lc_b),
    .disp_bcd(disp_b), .running(run_b), .lap_active(lap_b), .wrap(wrap_b)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock on instance a; inputs applied 1 time unit after the previous edge.
  task automatic cyc(input logic ss, input logic lc, input logic tk);
    ss_a = ss; lc_a = lc; tick_a = tk;
    @(posedge clk); #1;
    ss_a = 1'b0; lc_a = 1'b0; tick_a = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
  endtask

  task automatic cyc_b(input logic ss, input logic tk);
    ss_b = ss; tick_b = tk;
    @(posedge clk); #1;
    ss_b = 1'b0; tick_b = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    logic wrap_seen;
    // Reset / idle
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_disp", disp_a, 16'h0000);
    chk("rst_running", 16'(run_a), 16'h0);
    chk("rst_lap", 16'(lap_a), 16'h0);
    chk("rst_wrap", 16'(wrap_a), 16'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("idle_disp", disp_a, 16'h0000);
      chk("idle_running", 16'(run_a), 16'h0);
      chk("idle_wrap", 16'(wrap_a), 16'h0);
    end

    // Start and count
    cyc(1'b1, 1'b0, 1'b0);
    chk("start_running", 16'(run_a), 16'h1);
    chk("start_lap", 16'(lap_a), 16'h0);
    ticks(24);
    cyc(1'b0, 1'b0, 1'b0);
    chk("count_12", disp_a, 16'h0012);
    ticks(96);
    cyc(1'b0, 1'b0, 1'b0);
    chk("count_0100", disp_a, 16'h0100);
    chk("count_nowrap", 16'(wrap_a), 16'h0);

    // Lap freeze
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    ticks(10);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_active", 16'(lap_a), 16'h1);
    chk("lap_running", 16'(run_a), 16'h1);
    chk("lap_capture", disp_a, 16'h0005);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("lap_hold", disp_a, 16'h0005);
    end
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap_exit_flag", 16'(lap_a), 16'h0);
    chk("lap_exit_running", 16'(run_a), 16'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("lap_exit_live", disp_a, 16'h0010);

    // Pause / resume / clear
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    ticks(7);
    cyc(1'b1, 1'b0, 1'b0);
    chk("pause_running", 16'(run_a), 16'h0);
    ticks(20);
    cyc(1'b0, 1'b0, 1'b0);
    chk("pause_hold", disp_a, 16'h0003);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("resume_presc_kept", disp_a, 16'h0004);
    ticks(1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("clear_running", 16'(run_a), 16'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clear_disp", disp_a, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("idle_lc_ignored", 16'(run_a), 16'h0);
    cyc(1'b1, 1'b0, 1'b0);
    ticks(1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("clear_presc_zero", disp_a, 16'h0000);
    ticks(1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("after_clear_count", disp_a, 16'h0001);

    // Priority and tick-on-stop
    cyc(1'b1, 1'b1, 1'b0);
    chk("prio_running", 16'(run_a), 16'h0);
    chk("prio_lap", 16'(lap_a), 16'h0);
    cyc(1'b1, 1'b0, 1'b1);
    chk("resume_running", 16'(run_a), 16'h1);
    cyc(1'b0, 1'b0, 1'b0);
    chk("resume_tick_dropped", disp_a, 16'h0001);
    ticks(1);
    cyc(1'b1, 1'b0, 1'b1);
    chk("stop_running", 16'(run_a), 16'h0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("stop_tick_counted", disp_a, 16'h0002);

    // Reset mid-run in LAP
    do_reset();
    cyc(1'b1, 1'b0, 1'b0);
    ticks(84);
    cyc(1'b0, 1'b1, 1'b0);
    chk("lap42_disp", disp_a, 16'h0042);
    chk("lap42_flag", 16'(lap_a), 16'h1);
    ss_a = 1'b1; tick_a = 1'b1;
    do_reset();
    ss_a = 1'b0; tick_a = 1'b0;
    chk("midrst_disp", disp_a, 16'h0000);
    chk("midrst_lap", 16'(lap_a), 16'h0);
    chk("midrst_running", 16'(run_a), 16'h0);

    // Full wrap on instance b
    cyc_b(1'b1, 1'b0);
    chk("b_running", 16'(run_b), 16'h1);
    wrap_seen = 1'b0;
    for (int i = 0; i < 3599; i++) begin
      cyc_b(1'b0, 1'b1);
      if (wrap_b) wrap_seen = 1'b1;
    end
    cyc_b(1'b0, 1'b0);
    chk("b_max", disp_b, 16'h5959);
    chk("b_no_early_wrap", 16'(wrap_seen), 16'h0);
    cyc_b(1'b0, 1'b1);
    chk("b_wrap_pulse", 16'(wrap_b), 16'h1);
    cyc_b(1'b0, 1'b0);
    chk("b_wrap_end", 16'(wrap_b), 16'h0);
    chk("b_wrap_disp", disp_b, 16'h0000);
    cyc_b(1'b0, 1'b1);
    cyc_b(1'b0, 1'b0);
    chk("b_after_wrap", disp_b, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
